matvec_job_arbiter: RTL and testbench

Round-robin scheduler that shares one 8x8 matrix-vector engine among NREQ requesters. Each requester submits a job: a full matrix plus vector, or a vector only. The arbiter grants one job at a time, forwards that job's input stream into the engine, and routes the engine's K results back to the granted requester with a requester tag. It tracks which requester owns the matrix currently resident in the engine. A vector-only job is eligible only for that owner. The block sits between requester-side stream ports and the engine's input/output handshake ports.

---
 rtl/matvec_job_arbiter.sv | 177 +++++++++++++++++
 tb/tb_matvec_job_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_job_arbiter.sv
// Round-robin job arbiter sharing one KxK matrix-vector engine among NREQ requesters.
// Input and result streams are passed through combinationally; only control state is registered.
module matvec_job_arbiter #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned K    = 8,
  parameter  int unsigned DW   = 14,
  parameter  int unsigned OW   = 28,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_new_matrix,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eng_input_valid,
  input  logic                 eng_input_ready,
  output logic [DW-1:0]        eng_input_data,
  output logic                 eng_new_matrix,
  input  logic                 eng_output_valid,
  output logic                 eng_output_ready,
  input  logic [OW-1:0]        eng_output_data,
  output logic                 rsp_valid,
  output logic [IW-1:0]        rsp_id,
  output logic [OW-1:0]        rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 busy,
  output logic                 mat_valid,
  output logic [IW-1:0]        mat_owner
);

  localparam int unsigned LEN_NM = K * K + K;
  localparam int unsigned WCW    = $clog2(K * K + K + 1);
  localparam int unsigned OCW    = $clog2(K + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic           job_nm_q, job_nm_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [OCW-1:0] ocnt_q, ocnt_d;
  logic           mat_valid_q, mat_valid_d;
  logic [IW-1:0]  mat_owner_q, mat_owner_d;

  logic [DW-1:0]   req_word [NREQ];
  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   cand;
  logic            in_fire, out_fire, last_word, last_rsp;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
    assign req_word[gi] = req_data[gi*DW +: DW];
  end

  // Vector-only jobs are eligible only for the requester whose matrix is resident
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & (req_new_matrix[i] | (mat_valid_q & (mat_owner_q == IW'(i))));
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_q) + k) % NREQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign in_fire   = (state_q == ST_LOAD) & req_valid[grant_q] & eng_input_ready;
  assign out_fire  = (state_q == ST_DRAIN) & eng_output_valid & rsp_ready[grant_q];
  assign last_word = job_nm_q ? (wcnt_q == WCW'(LEN_NM - 1)) : (wcnt_q == WCW'(K - 1));
  assign last_rsp  = (ocnt_q == OCW'(K - 1));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    job_nm_d    = job_nm_q;
    wcnt_d      = wcnt_q;
    ocnt_d      = ocnt_q;
    mat_valid_d = mat_valid_q;
    mat_owner_d = mat_owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d  = win_id;
          job_nm_d = req_new_matrix[win_id];
          wcnt_d   = '0;
          ocnt_d   = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_fire) begin
          wcnt_d = wcnt_q + WCW'(1);
          if (last_word) begin
            state_d = ST_DRAIN;
            if (job_nm_q) begin
              mat_valid_d = 1'b1;
              mat_owner_d = grant_q;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          ocnt_d = ocnt_q + OCW'(1);
          if (last_rsp) begin
            state_d = ST_IDLE;
            rr_d    = IW'((32'(grant_q) + 1) % NREQ);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      job_nm_q    <= 1'b0;
      wcnt_q      <= '0;
      ocnt_q      <= '0;
      mat_valid_q <= 1'b0;
      mat_owner_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      job_nm_q    <= job_nm_d;
      wcnt_q      <= wcnt_d;
      ocnt_q      <= ocnt_d;
      mat_valid_q <= mat_valid_d;
      mat_owner_q <= mat_owner_d;
    end
  end

  // Zero-latency stream steering for the granted requester
  always_comb begin
    req_ready        = '0;
    eng_input_valid  = 1'b0;
    eng_input_data   = '0;
    eng_new_matrix   = 1'b0;
    eng_output_ready = 1'b0;
    rsp_valid        = 1'b0;
    rsp_id           = '0;
    if (state_q == ST_LOAD) begin
      req_ready[grant_q] = eng_input_ready;
      eng_input_valid    = req_valid[grant_q];
      eng_input_data     = req_word[grant_q];
      eng_new_matrix     = job_nm_q;
    end
    if (state_q == ST_DRAIN) begin
      rsp_valid        = eng_output_valid;
      rsp_id           = grant_q;
      eng_output_ready = rsp_ready[grant_q];
    end
  end

  assign rsp_data  = eng_output_data;
  assign busy      = (state_q != ST_IDLE);
  assign mat_valid = mat_valid_q;
  assign mat_owner = mat_owner_q;

endmodule

// File: tb/tb_matvec_job_arbiter.sv
// Randomized bench for matvec_job_arbiter: behavioural engine, job-level schedule model,
// result scoreboard.
module tb_matvec_job_arbiter;

  localparam int NREQ = 4;
  localparam int K    = 8;
  localparam int DW   = 14;
  localparam int OW   = 28;
  localparam int IW   = 2;
  localparam int FULL = K * K + K;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_new_matrix, req_ready, rsp_ready;
  logic [NREQ*DW-1:0] req_data;
  logic              eng_input_valid, eng_input_ready, eng_new_matrix;
  logic [DW-1:0]     eng_input_data;
  logic              eng_output_valid, eng_output_ready;
  logic [OW-1:0]     eng_output_data, rsp_data;
  logic              rsp_valid, busy, mat_valid;
  logic [IW-1:0]     rsp_id, mat_owner;

  matvec_job_arbiter #(.NREQ(NREQ), .K(K), .DW(DW), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_new_matrix(req_new_matrix), .req_data(req_data),
    .req_ready(req_ready),
    .eng_input_valid(eng_input_valid), .eng_input_ready(eng_input_ready),
    .eng_input_data(eng_input_data), .eng_new_matrix(eng_new_matrix),
    .eng_output_valid(eng_output_valid), .eng_output_ready(eng_output_ready),
    .eng_output_data(eng_output_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .mat_valid(mat_valid), .mat_owner(mat_owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side pending jobs
  int  word_q [NREQ][$];
  bit  nm_q   [NREQ][$];
  int  widx   [NREQ];

  // Job-level schedule model and scoreboard
  int  rr_m, mo_m;
  bit  mv_m;
  int  cur_w [K*K];
  int  exp_order [$];
  int  exp_id [$];
  int  exp_dat [$];
  int  rcnt, gap_st;
  bit  hung;

  // Behavioural engine
  int  e_cnt, e_idx;
  bit  e_nm, e_out;
  int  e_w [K*K];
  int  e_x [K];
  int  e_y [K];

  int  eg, nfire;
  bit  efire, ofire, rfire;

  task automatic clear_state();
    for (int r = 0; r < NREQ; r++) begin
      word_q[r].delete();
      nm_q[r].delete();
      widx[r] = 0;
    end
    exp_order.delete();
    exp_id.delete();
    exp_dat.delete();
    rr_m = 0; mv_m = 1'b0; mo_m = 0;
    e_cnt = 0; e_idx = 0; e_nm = 1'b0; e_out = 1'b0;
    rcnt = 0; gap_st = 0;
  endtask

  task automatic post(input int r, input bit nm, input bit ident);
    int len;
    int w;
    len = nm ? FULL : K;
    for (int n = 0; n < len; n++) begin
      if (ident) w = (nm && n < K*K) ? ((n / K == n % K) ? 1 : 0) : (n - (nm ? K*K : 0) + 1);
      else       w = int'($urandom_range(0, 100)) - 50;
      word_q[r].push_back(w);
    end
    nm_q[r].push_back(nm);
  endtask

  task automatic withdraw(input int r);
    int len;
    if (nm_q[r].size() > 0) begin
      len = nm_q[r][0] ? FULL : K;
      repeat (len) void'(word_q[r].pop_front());
      void'(nm_q[r].pop_front());
    end
  endtask

  task automatic withdraw_all();
    for (int r = 0; r < NREQ; r++) while (nm_q[r].size() > 0) withdraw(r);
  endtask

  // Serve pending jobs in round-robin order under the ownership rule; each served job
  // yields its expected grant and K results W*x.
  task automatic plan();
    int jp [NREQ];
    int wo [NREQ];
    int x  [K];
    int g, y, r;
    for (int i = 0; i < NREQ; i++) begin jp[i] = 0; wo[i] = 0; end
    while (1) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        r = (rr_m + k) % NREQ;
        if (g < 0 && jp[r] < nm_q[r].size())
          if (nm_q[r][jp[r]] || (mv_m && mo_m == r)) g = r;
      end
      if (g < 0) break;
      if (nm_q[g][jp[g]]) begin
        for (int n = 0; n < K*K; n++) cur_w[n] = word_q[g][wo[g] + n];
        wo[g] += K*K;
        mv_m = 1'b1;
        mo_m = g;
      end
      for (int n = 0; n < K; n++) x[n] = word_q[g][wo[g] + n];
      wo[g] += K;
      for (int i = 0; i < K; i++) begin
        y = 0;
        for (int j = 0; j < K; j++) y += cur_w[i*K + j] * x[j];
        exp_id.push_back(g);
        exp_dat.push_back(y);
      end
      exp_order.push_back(g);
      jp[g]++;
      rr_m = (g + 1) % NREQ;
    end
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    if (!hung) begin
      while ((exp_order.size() > 0 || exp_id.size() > 0 || busy) && cyc < 20000) begin
        @(negedge clk); #2;
        cyc++;
      end
      if (cyc >= 20000) begin
        chk("job_timeout", exp_id.size(), 0);
        hung = 1'b1;
      end
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic chk_mat();
    chk("mat_valid", mat_valid, mv_m);
    if (mv_m) chk("mat_owner", mat_owner, mo_m);
  endtask

  task automatic check_stuck();
    repeat (4) begin
      @(negedge clk); #2;
      for (int r = 0; r < NREQ; r++)
        if (nm_q[r].size() > 0) chk($sformatf("stuck_ready%0d", r), req_ready[r], 0);
      chk("stuck_idle", busy, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"},      busy, 0);
    chk({pfx, "_mat_valid"}, mat_valid, 0);
    chk({pfx, "_mat_owner"}, mat_owner, 0);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_in_valid"},  eng_input_valid, 0);
    chk({pfx, "_eng_nm"},    eng_new_matrix, 0);
    chk({pfx, "_out_ready"}, eng_output_ready, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_id"},    rsp_id, 0);
  endtask

  // Per-cycle driver and monitor: drive at negedge, observe settled handshakes 1ns later
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        req_valid = '0; req_new_matrix = '0; req_data = '0; rsp_ready = '0;
        eng_input_ready = 1'b0; eng_output_valid = 1'b0; eng_output_data = '0;
      end else begin
        for (int r = 0; r < NREQ; r++) begin
          if (word_q[r].size() > 0) begin
            req_valid[r]          = (widx[r] == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            req_new_matrix[r]     = (widx[r] == 0) ? nm_q[r][0] : 1'($urandom_range(0, 1));
            req_data[r*DW +: DW]  = DW'(word_q[r][0]);
          end else begin
            req_valid[r]          = 1'b0;
            req_new_matrix[r]     = 1'($urandom_range(0, 1));
            req_data[r*DW +: DW]  = DW'($urandom);
          end
          rsp_ready[r] = ($urandom_range(0, 3) != 0);
        end
        eng_input_ready  = !e_out && ($urandom_range(0, 7) != 0);
        eng_output_valid = e_out && ($urandom_range(0, 5) != 0);
        eng_output_data  = e_out ? OW'(e_y[e_idx]) : OW'($urandom);
        #1;
        if (gap_st == 1) begin
          chk("gap_idle", busy, 0);
          gap_st = 2;
        end else if (gap_st == 2) begin
          chk("next_grant_busy", busy, exp_order.size() > 0);
          gap_st = 0;
        end
        chk("ready_onehot", $countones(req_ready) <= 1, 1);

        nfire = 0;
        for (int r = 0; r < NREQ; r++) begin
          if (req_valid[r] && req_ready[r]) begin
            nfire++;
            if (widx[r] == 0) begin
              eg = -1;
              if (exp_order.size() > 0) eg = exp_order.pop_front();
              chk("grant", r, eg);
              chk("job_type", eng_new_matrix, nm_q[r][0]);
            end
            chk("fwd_data", $signed(eng_input_data), word_q[r][0]);
            void'(word_q[r].pop_front());
            widx[r]++;
            if (widx[r] == (nm_q[r][0] ? FULL : K)) begin
              widx[r] = 0;
              void'(nm_q[r].pop_front());
            end
          end
        end

        efire = eng_input_valid && eng_input_ready;
        if (efire || nfire > 0) chk("in_xfer", efire, nfire);
        if (efire) begin
          if (e_cnt == 0) e_nm = eng_new_matrix;
          else            chk("nm_hold", eng_new_matrix, e_nm);
          if (e_nm && e_cnt < K*K) e_w[e_cnt] = $signed(eng_input_data);
          else                     e_x[e_cnt - (e_nm ? K*K : 0)] = $signed(eng_input_data);
          e_cnt++;
          if (e_cnt == (e_nm ? FULL : K)) begin
            for (int i = 0; i < K; i++) begin
              e_y[i] = 0;
              for (int j = 0; j < K; j++) e_y[i] += e_w[i*K + j] * e_x[j];
            end
            e_out = 1'b1; e_idx = 0; e_cnt = 0;
          end
        end

        ofire = eng_output_valid && eng_output_ready;
        rfire = rsp_valid && rsp_ready[rsp_id];
        if (ofire || rfire) chk("out_xfer", rfire, ofire);
        if (ofire) begin
          e_idx++;
          if (e_idx == K) e_out = 1'b0;
        end
        if (rfire) begin
          chk("rsp_expected", exp_id.size() > 0, 1);
          if (exp_id.size() > 0) begin
            chk("rsp_id", rsp_id, exp_id.pop_front());
            chk("rsp_data", $signed(rsp_data), exp_dat.pop_front());
          end
          rcnt++;
          if (rcnt == K) begin
            rcnt = 0;
            gap_st = 1;
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    reset = 1'b0;
    hung  = 1'b0;
    clear_state();
    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Identity matrix, x = 1..8
    post(0, 1'b1, 1'b1); plan(); wait_done(); chk_mat();

    // All four in the same cycle, then 1 and 3 only
    for (int r = 0; r < NREQ; r++) post(r, 1'b1, 1'b0);
    plan(); wait_done(); chk_mat();
    post(1, 1'b1, 1'b0); post(3, 1'b1, 1'b0); plan(); wait_done(); chk_mat();

    // Ownership filter
    post(0, 1'b1, 1'b0); post(2, 1'b0, 1'b0); plan(); wait_done(); check_stuck();
    post(0, 1'b0, 1'b0); plan(); wait_done(); check_stuck(); chk_mat();

    // Ownership transfer to requester 3
    post(3, 1'b1, 1'b0); plan(); wait_done(); chk_mat();
    post(0, 1'b0, 1'b0); plan(); wait_done(); check_stuck();
    withdraw(0);
    post(0, 1'b1, 1'b0); post(0, 1'b0, 1'b0); plan(); wait_done(); chk_mat();
    withdraw_all();

    // Random job mixes
    repeat (6) begin
      for (int r = 0; r < NREQ; r++)
        repeat ($urandom_range(0, 2)) post(r, 1'($urandom_range(0, 1)), 1'b0);
      plan(); wait_done(); chk_mat(); check_stuck();
      withdraw_all();
    end

    // Reset in the middle of a matrix load
    post(1, 1'b1, 1'b0); plan();
    cyc = 0;
    while (widx[1] < 30 && cyc < 5000) begin
      @(negedge clk); #3;
      cyc++;
    end
    chk("reached_word30", widx[1] >= 30, 1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    clear_state();
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b1;
    post(2, 1'b1, 1'b0); post(1, 1'b1, 1'b1); plan(); wait_done(); chk_mat();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
